// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
// Optional build macro used by the chain: PIPE_OCCUPANCY_EN.
package pipe_pkg;

  // Above this depth the combinational ready path through all stages gets long.
  localparam int PIPE_MAX_COMB_DEPTH = 4;

  // Bits needed to count 0..depth occupied stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // pipe_word pattern, declared locally where WIDTH is known:
  //   typedef struct packed {logic valid; logic [WIDTH-1:0] data;} pipe_word;

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: a valid bit plus a data word, loaded on an upstream
// handshake and drained when the downstream side is ready.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_rdy_in,
  output logic             rdy_out,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } pipe_word;

  pipe_word word_reg;
  logic     load;

  assign rdy_out = !word_reg.valid || dn_rdy_in;
  assign load    = up_valid && rdy_out && !flush;
  assign valid   = word_reg.valid;
  assign data    = word_reg.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg.valid <= 1'b0;
      word_reg.data  <= RESET_VAL;
    end else begin
      if (flush) begin
        word_reg.valid <= 1'b0;
      end else if (load) begin
        word_reg.valid <= 1'b1;
      end else if (rdy_out) begin
        word_reg.valid <= 1'b0;
      end
      // Data only moves with a word, so bubbles never toggle it.
      if (load) begin
        word_reg.data <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage elastic register chain with valid/ready backpressure and flush.
// Define PIPE_OCCUPANCY_EN to add the registered occupancy count output.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  if (DEPTH < 1) begin : g_depth_err
    $error("pipe_reg_chain: DEPTH must be at least 1");
  end
  if (DEPTH > PIPE_MAX_COMB_DEPTH) begin : g_depth_warn
    $warning("pipe_reg_chain: ready path spans more than PIPE_MAX_COMB_DEPTH stages");
  end

  logic [DEPTH-1:0] v_vec;
  logic [WIDTH-1:0] d_arr [DEPTH];

  // Each stage keeps its own ready net so the ripple from the output stage
  // back to stage 0 is a plain chain of distinct signals (the critical path).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             dn_rdy;
    logic             rdy;

    if (gi == 0) begin : g_first
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_next
      assign up_v = v_vec[gi-1];
      assign up_d = d_arr[gi-1];
    end

    if (gi == DEPTH - 1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_body
      assign dn_rdy = g_stage[gi+1].rdy;
    end

    pipe_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (up_v),
      .up_data  (up_d),
      .dn_rdy_in(dn_rdy),
      .rdy_out  (rdy),
      .valid    (v_vec[gi]),
      .data     (d_arr[gi])
    );
  end

  assign in_ready  = g_stage[0].rdy && !flush;
  assign out_valid = v_vec[DEPTH-1] && !flush;
  assign out_data  = d_arr[DEPTH-1];

`ifdef PIPE_OCCUPANCY_EN
  localparam int OW = occ_width(DEPTH);

  logic [OW-1:0] occ_reg;
  logic          in_hs;
  logic          out_hs;

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign occupancy = occ_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= '0;
    end else if (flush) begin
      occ_reg <= '0;
    end else if (in_hs && !out_hs) begin
      occ_reg <= occ_reg + OW'(1);
    end else if (!in_hs && out_hs) begin
      occ_reg <= occ_reg - OW'(1);
    end
  end

  occ_matches_valids: assert property (@(posedge clk) disable iff (!rst_n)
    int'(occ_reg) == $countones(v_vec));
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (WIDTH=8, DEPTH=3) against a slot-level
// reference model; also checks occupancy when PIPE_OCCUPANCY_EN is defined.
module tb_pipe_reg_chain;

  localparam int W = 8;
  localparam int D = 3;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         flush     = 1'b0;
  logic         in_valid  = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
`ifdef PIPE_OCCUPANCY_EN
  logic [1:0]   occupancy;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: one slot per stage, words slide forward into free slots.
  bit           mv [D];
  logic [W-1:0] md [D];

  always #5 clk = ~clk;

  pipe_reg_chain #(
    .WIDTH    (W),
    .DEPTH    (D),
    .RESET_VAL(8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
`ifdef PIPE_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit has_room(input bit ordy);
    bit r = ordy;
    for (int i = 0; i < D; i++) if (!mv[i]) r = 1'b1;
    return r;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < D; i++) if (mv[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      mv[i] = 1'b0;
      md[i] = 8'h00;
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance model at the edge.
  task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy,
                      input bit fl, output bit acc);
    bit exp_ir;
    bit exp_ov;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #2;
    exp_ir = has_room(ordy) && !fl;
    exp_ov = mv[D-1] && !fl;
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (mv[D-1]) chk("out_data", out_data, md[D-1]);
`ifdef PIPE_OCCUPANCY_EN
    chk("occupancy", occupancy, model_count());
`endif
    if (exp_ov && ordy) $display("OUT  data=%02h", md[D-1]);
    if (exp_ir && iv)   $display("IN   data=%02h", id);
    if (fl)             $display("FLUSH");
    acc = iv && exp_ir;
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < D; i++) mv[i] = 1'b0;
    end else begin
      if (mv[D-1] && ordy) mv[D-1] = 1'b0;
      for (int i = D - 2; i >= 0; i--) begin
        if (mv[i] && !mv[i+1]) begin
          mv[i+1] = 1'b1;
          md[i+1] = md[i];
          mv[i]   = 1'b0;
        end
      end
      if (acc) begin
        mv[0] = 1'b1;
        md[0] = id;
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    bit first_out_seen;
    int lat;
    model_reset();

    // Reset: outputs settle without any clock edge.
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming: 11,22,33 back-to-back; first output visible D cycles after accept.
    step(1'b1, 8'h11, 1'b1, 1'b0, acc);
    chk("stream_accept", acc, 1'b1);
    step(1'b1, 8'h22, 1'b1, 1'b0, acc);
    step(1'b1, 8'h33, 1'b1, 1'b0, acc);
    lat = 3;
    first_out_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!first_out_seen && out_valid) first_out_seen = 1'b1;
      if (!first_out_seen) lat++;
      step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    end
    chk("stream_latency", lat, D);

    // Stall and fill: three accepted, fourth refused until space frees.
    step(1'b1, 8'hA1, 1'b0, 1'b0, acc);
    step(1'b1, 8'hA2, 1'b0, 1'b0, acc);
    step(1'b1, 8'hA3, 1'b0, 1'b0, acc);
    step(1'b1, 8'hA4, 1'b0, 1'b0, acc);
    chk("full_refuses", acc, 1'b0);
    step(1'b1, 8'hA4, 1'b0, 1'b0, acc);
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) step(1'b1, 8'hA4, 1'b1, 1'b0, acc);
    chk("a4_accepted", acc, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Bubble collapse: only the output stage occupied, downstream stalled.
    step(1'b1, 8'hC3, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    step(1'b1, 8'h5A, 1'b0, 1'b0, acc);
    chk("bubble_accept", acc, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Flush with a full chain and a live input word that must be dropped.
    step(1'b1, 8'h01, 1'b0, 1'b0, acc);
    step(1'b1, 8'h02, 1'b0, 1'b0, acc);
    step(1'b1, 8'h03, 1'b0, 1'b0, acc);
    step(1'b1, 8'hFF, 1'b0, 1'b1, acc);
    chk("flush_refuses", acc, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Reset mid-transfer: words vanish immediately.
    step(1'b1, 8'h71, 1'b0, 1'b0, acc);
    step(1'b1, 8'h72, 1'b0, 1'b0, acc);
    step(1'b1, 8'h73, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, 8'h00);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Randomised traffic with occasional stalls and flushes.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0), acc);
    end
    for (int k = 0; k < 6; k++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
